// File: rtl/tlb_unit_if.sv
// -----------------------------------------------------------------------------
// tlb_pkg / tlb_unit_if
//
// Purpose:
//   tlb_pkg holds the TLB entry layout. cp0 uses the same layout on
//   tlbrw_wdata and tlbr_res.
//   tlb_unit_if bundles the request/response traffic between the pipeline/cp0
//   and the TLB. clk/rst are not part of the bundle.
//
// Signal summary:
//   asid                      current ASID (cp0 entry_hi[7:0])
//   inst_req/inst_vaddr       instruction lookup request
//   inst_paddr/miss/invalid/uncached   instruction lookup result (registered)
//   data_req/data_vaddr       data lookup request
//   data_paddr/miss/invalid/dirty/uncached   data lookup result (registered)
//   tlbp_req/tlbp_vpn2 -> tlbp_res     probe
//   tlbr_req/tlbr_index -> tlbr_res    indexed read
//   tlbw_we/tlbw_index/tlbw_wdata      indexed write (TLBWI/TLBWR)
//
// Modports: master = pipeline/cp0 side, slave = tlb_unit.
// -----------------------------------------------------------------------------
package tlb_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [23:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [23:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

interface tlb_unit_if #(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
);
    import tlb_pkg::*;

    logic [7:0]       asid;

    logic             inst_req;
    logic [31:0]      inst_vaddr;
    logic [31:0]      inst_paddr;
    logic             inst_miss;
    logic             inst_invalid;
    logic             inst_uncached;

    logic             data_req;
    logic [31:0]      data_vaddr;
    logic [31:0]      data_paddr;
    logic             data_miss;
    logic             data_invalid;
    logic             data_dirty;
    logic             data_uncached;

    logic             tlbp_req;
    logic [18:0]      tlbp_vpn2;
    logic [31:0]      tlbp_res;

    logic             tlbr_req;
    logic [IDX_W-1:0] tlbr_index;
    tlb_entry_t       tlbr_res;

    logic             tlbw_we;
    logic [IDX_W-1:0] tlbw_index;
    tlb_entry_t       tlbw_wdata;

    modport master (
        output asid,
        output inst_req, inst_vaddr,
        input  inst_paddr, inst_miss, inst_invalid, inst_uncached,
        output data_req, data_vaddr,
        input  data_paddr, data_miss, data_invalid, data_dirty, data_uncached,
        output tlbp_req, tlbp_vpn2,
        input  tlbp_res,
        output tlbr_req, tlbr_index,
        input  tlbr_res,
        output tlbw_we, tlbw_index, tlbw_wdata
    );

    modport slave (
        input  asid,
        input  inst_req, inst_vaddr,
        output inst_paddr, inst_miss, inst_invalid, inst_uncached,
        input  data_req, data_vaddr,
        output data_paddr, data_miss, data_invalid, data_dirty, data_uncached,
        input  tlbp_req, tlbp_vpn2,
        output tlbp_res,
        input  tlbr_req, tlbr_index,
        output tlbr_res,
        input  tlbw_we, tlbw_index, tlbw_wdata
    );
endinterface

// File: rtl/tlb_unit.sv
// -----------------------------------------------------------------------------
// tlb_unit
//
// Purpose:
//   Fully associative TLB that sits beside cp0. It holds NUM_ENTRIES entries in
//   flops. It provides:
//   - registered translation for the instruction port and the data port;
//   - TLBP probe, TLBR read and TLBWI/TLBWR write for cp0.
//   When several entries match, the lowest index wins.
//   Every request is treated as mapped. Unmapped segments are resolved before
//   this block.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset. Clears all entries and all outputs.
//   bus   tlb_unit_if.slave, carrying all request and response traffic.
//
// Timing:
//   A lookup, probe or read answers one cycle after its strobe.
//   The answer holds until the next strobe on the same port.
//   A write lands at the edge. Same-cycle requests see the old contents.
// -----------------------------------------------------------------------------
module tlb_unit
    import tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input logic       clk,
    input logic       rst,
    tlb_unit_if.slave bus
);

    tlb_entry_t entries_q [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] instMatch, dataMatch, probeMatch;
    logic [IDX_W-1:0]       instIdx, dataIdx, probeIdx;

    logic [31:0] instPaddr_q, instPaddr_d;
    logic        instMiss_q, instMiss_d;
    logic        instInvalid_q, instInvalid_d;
    logic        instUncached_q, instUncached_d;

    logic [31:0] dataPaddr_q, dataPaddr_d;
    logic        dataMiss_q, dataMiss_d;
    logic        dataInvalid_q, dataInvalid_d;
    logic        dataDirty_q, dataDirty_d;
    logic        dataUncached_q, dataUncached_d;

    logic [31:0] tlbpRes_q, tlbpRes_d;
    tlb_entry_t  tlbrRes_q;

    // Priority encoder: the lowest set bit wins.
    // Scanning from the top down lets lower indices overwrite higher ones.
    function automatic logic [IDX_W-1:0] lowestSet(input logic [NUM_ENTRIES-1:0] v);
        lowestSet = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) lowestSet = IDX_W'(i);
        end
    endfunction

    // Compare all entries in parallel for both ports and the probe.
    always_comb begin
        instMatch  = '0;
        dataMatch  = '0;
        probeMatch = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            instMatch[i]  = (entries_q[i].vpn2 == bus.inst_vaddr[31:13]) &&
                            (entries_q[i].g || entries_q[i].asid == bus.asid);
            dataMatch[i]  = (entries_q[i].vpn2 == bus.data_vaddr[31:13]) &&
                            (entries_q[i].g || entries_q[i].asid == bus.asid);
            probeMatch[i] = (entries_q[i].vpn2 == bus.tlbp_vpn2) &&
                            (entries_q[i].g || entries_q[i].asid == bus.asid);
        end
        instIdx  = lowestSet(instMatch);
        dataIdx  = lowestSet(dataMatch);
        probeIdx = lowestSet(probeMatch);
    end

    // Build the next translation results.
    // vaddr[12] picks the even or odd page.
    // On a miss, paddr and all flags are zero.
    // On an invalid page, paddr is still formed.
    always_comb begin
        instPaddr_d    = '0;
        instMiss_d     = 1'b1;
        instInvalid_d  = 1'b0;
        instUncached_d = 1'b0;
        if (|instMatch) begin
            instMiss_d = 1'b0;
            if (bus.inst_vaddr[12]) begin
                instPaddr_d    = {entries_q[instIdx].pfn1[19:0], bus.inst_vaddr[11:0]};
                instInvalid_d  = ~entries_q[instIdx].v1;
                instUncached_d = (entries_q[instIdx].c1 == 3'd2);
            end else begin
                instPaddr_d    = {entries_q[instIdx].pfn0[19:0], bus.inst_vaddr[11:0]};
                instInvalid_d  = ~entries_q[instIdx].v0;
                instUncached_d = (entries_q[instIdx].c0 == 3'd2);
            end
        end

        dataPaddr_d    = '0;
        dataMiss_d     = 1'b1;
        dataInvalid_d  = 1'b0;
        dataDirty_d    = 1'b0;
        dataUncached_d = 1'b0;
        if (|dataMatch) begin
            dataMiss_d = 1'b0;
            if (bus.data_vaddr[12]) begin
                dataPaddr_d    = {entries_q[dataIdx].pfn1[19:0], bus.data_vaddr[11:0]};
                dataInvalid_d  = ~entries_q[dataIdx].v1;
                dataDirty_d    = entries_q[dataIdx].d1;
                dataUncached_d = (entries_q[dataIdx].c1 == 3'd2);
            end else begin
                dataPaddr_d    = {entries_q[dataIdx].pfn0[19:0], bus.data_vaddr[11:0]};
                dataInvalid_d  = ~entries_q[dataIdx].v0;
                dataDirty_d    = entries_q[dataIdx].d0;
                dataUncached_d = (entries_q[dataIdx].c0 == 3'd2);
            end
        end

        // A probe miss sets only the P bit; the index field stays zero.
        tlbpRes_d = (|probeMatch) ? 32'(probeIdx) : 32'h8000_0000;
    end

    // Entry storage. Requests in this cycle read entries_q before the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
        end else if (bus.tlbw_we) begin
            entries_q[bus.tlbw_index] <= bus.tlbw_wdata;
        end
    end

    // Result registers. Each port updates only on its own strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            instPaddr_q    <= '0;
            instMiss_q     <= 1'b0;
            instInvalid_q  <= 1'b0;
            instUncached_q <= 1'b0;
            dataPaddr_q    <= '0;
            dataMiss_q     <= 1'b0;
            dataInvalid_q  <= 1'b0;
            dataDirty_q    <= 1'b0;
            dataUncached_q <= 1'b0;
            tlbpRes_q      <= '0;
            tlbrRes_q      <= '0;
        end else begin
            if (bus.inst_req) begin
                instPaddr_q    <= instPaddr_d;
                instMiss_q     <= instMiss_d;
                instInvalid_q  <= instInvalid_d;
                instUncached_q <= instUncached_d;
            end
            if (bus.data_req) begin
                dataPaddr_q    <= dataPaddr_d;
                dataMiss_q     <= dataMiss_d;
                dataInvalid_q  <= dataInvalid_d;
                dataDirty_q    <= dataDirty_d;
                dataUncached_q <= dataUncached_d;
            end
            if (bus.tlbp_req) tlbpRes_q <= tlbpRes_d;
            if (bus.tlbr_req) tlbrRes_q <= entries_q[bus.tlbr_index];
        end
    end

    assign bus.inst_paddr    = instPaddr_q;
    assign bus.inst_miss     = instMiss_q;
    assign bus.inst_invalid  = instInvalid_q;
    assign bus.inst_uncached = instUncached_q;
    assign bus.data_paddr    = dataPaddr_q;
    assign bus.data_miss     = dataMiss_q;
    assign bus.data_invalid  = dataInvalid_q;
    assign bus.data_dirty    = dataDirty_q;
    assign bus.data_uncached = dataUncached_q;
    assign bus.tlbp_res      = tlbpRes_q;
    assign bus.tlbr_res      = tlbrRes_q;

endmodule

// File: tb/tb_tlb_unit.sv
// -----------------------------------------------------------------------------
// tb_tlb_unit
//
// Self-checking bench for tlb_unit.
// A reference model predicts every output from an array of entries and a
// linear first-match search. The bench first runs the directed scenarios,
// then runs randomized traffic.
// -----------------------------------------------------------------------------
module tb_tlb_unit;
    import tlb_pkg::*;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tlb_unit_if #(.NUM_ENTRIES(N)) bus ();

    tlb_unit #(.NUM_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: the entry table and the held result of each port.
    tlb_entry_t  mEntries [N];
    logic [31:0] eInstPaddr, eDataPaddr, eTlbp;
    logic        eInstMiss, eInstInv, eInstUnc;
    logic        eDataMiss, eDataInv, eDataDirty, eDataUnc;
    tlb_entry_t  eTlbr;

    // Count one comparison and report it if it mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic tlb_entry_t makeEntry(
        input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
        input logic [23:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
        input logic [23:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        tlb_entry_t e;
        e.vpn2 = vpn2; e.asid = asid; e.g = g;
        e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
        e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
        return e;
    endfunction

    // Return the first matching entry index, or -1 when nothing matches.
    function automatic int findEntry(input logic [18:0] vpn2, input logic [7:0] a);
        for (int i = 0; i < N; i++) begin
            if (mEntries[i].vpn2 == vpn2 && (mEntries[i].g || mEntries[i].asid == a)) return i;
        end
        return -1;
    endfunction

    task automatic modelTranslate(input logic [31:0] va, input logic [7:0] a,
                                  output logic [31:0] pa, output logic miss,
                                  output logic inv, output logic dirty, output logic unc);
        int k;
        logic [23:0] pfn;
        logic [2:0]  c;
        logic        v, d;
        k = findEntry(va[31:13], a);
        if (k < 0) begin
            pa = 32'h0; miss = 1'b1; inv = 1'b0; dirty = 1'b0; unc = 1'b0;
        end else begin
            pfn = va[12] ? mEntries[k].pfn1 : mEntries[k].pfn0;
            c   = va[12] ? mEntries[k].c1   : mEntries[k].c0;
            v   = va[12] ? mEntries[k].v1   : mEntries[k].v0;
            d   = va[12] ? mEntries[k].d1   : mEntries[k].d0;
            pa    = (pfn % 32'h0010_0000) * 32'h1000 + (va % 32'h1000);
            miss  = 1'b0;
            inv   = !v;
            dirty = d;
            unc   = (c == 3'd2);
        end
    endtask

    task automatic checkAll();
        checkOutput("instPaddr",    bus.inst_paddr,    eInstPaddr);
        checkOutput("instMiss",     bus.inst_miss,     eInstMiss);
        checkOutput("instInvalid",  bus.inst_invalid,  eInstInv);
        checkOutput("instUncached", bus.inst_uncached, eInstUnc);
        checkOutput("dataPaddr",    bus.data_paddr,    eDataPaddr);
        checkOutput("dataMiss",     bus.data_miss,     eDataMiss);
        checkOutput("dataInvalid",  bus.data_invalid,  eDataInv);
        checkOutput("dataDirty",    bus.data_dirty,    eDataDirty);
        checkOutput("dataUncached", bus.data_uncached, eDataUnc);
        checkOutput("tlbpRes",      bus.tlbp_res,      eTlbp);
        checkOutput("tlbrRes",      bus.tlbr_res,      eTlbr);
    endtask

    // Run one clock cycle with the inputs currently driven.
    // The model predicts from the pre-write table, then applies the write.
    // After the edge every output is compared, and the strobes drop back to idle.
    task automatic applyStimulus();
        logic [31:0] pa;
        logic        mi, iv, dr, uc;
        int          k;
        if (rst) begin
            for (int i = 0; i < N; i++) mEntries[i] = '0;
            eInstPaddr = '0; eInstMiss = 0; eInstInv = 0; eInstUnc = 0;
            eDataPaddr = '0; eDataMiss = 0; eDataInv = 0; eDataDirty = 0; eDataUnc = 0;
            eTlbp = '0; eTlbr = '0;
        end else begin
            if (bus.inst_req) begin
                modelTranslate(bus.inst_vaddr, bus.asid, pa, mi, iv, dr, uc);
                eInstPaddr = pa; eInstMiss = mi; eInstInv = iv; eInstUnc = uc;
            end
            if (bus.data_req) begin
                modelTranslate(bus.data_vaddr, bus.asid, pa, mi, iv, dr, uc);
                eDataPaddr = pa; eDataMiss = mi; eDataInv = iv; eDataDirty = dr; eDataUnc = uc;
            end
            if (bus.tlbp_req) begin
                k = findEntry(bus.tlbp_vpn2, bus.asid);
                eTlbp = (k < 0) ? 32'h8000_0000 : 32'(k);
            end
            if (bus.tlbr_req) eTlbr = mEntries[bus.tlbr_index];
            if (bus.tlbw_we)  mEntries[bus.tlbw_index] = bus.tlbw_wdata;
        end
        @(posedge clk);
        @(negedge clk);
        checkAll();
        rst          = 1'b0;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        bus.tlbp_req = 1'b0;
        bus.tlbr_req = 1'b0;
        bus.tlbw_we  = 1'b0;
    endtask

    function automatic logic [18:0] randVpn2();
        case ($urandom_range(0, 3))
            0:       return 19'h00200;
            1:       return 19'h00300;
            2:       return 19'h7FFFF;
            default: return 19'h00001;
        endcase
    endfunction

    function automatic logic [31:0] randVaddr();
        return {randVpn2(), 1'($urandom_range(0, 1)), 12'($urandom)};
    endfunction

    tlb_entry_t e3, e2, e7;

    initial begin
        rst            = 1'b1;
        bus.asid       = 8'h00;
        bus.inst_req   = 1'b0;
        bus.inst_vaddr = '0;
        bus.data_req   = 1'b0;
        bus.data_vaddr = '0;
        bus.tlbp_req   = 1'b0;
        bus.tlbp_vpn2  = '0;
        bus.tlbr_req   = 1'b0;
        bus.tlbr_index = '0;
        bus.tlbw_we    = 1'b0;
        bus.tlbw_index = '0;
        bus.tlbw_wdata = '0;

        // Reset: every output is expected to be zero.
        applyStimulus();
        checkOutput("rstDataPaddr", bus.data_paddr, 32'h0);

        // Empty table: the lookup misses and the probe reports P=1.
        bus.data_req = 1; bus.data_vaddr = 32'h0040_1000;
        bus.tlbp_req = 1; bus.tlbp_vpn2 = 19'h00200;
        applyStimulus();
        checkOutput("emptyMiss", bus.data_miss, 1'b1);
        checkOutput("emptyProbe", bus.tlbp_res, 32'h8000_0000);

        // Write entry 3, then translate the even and odd pages with asid 5.
        e3 = makeEntry(19'h00200, 8'h05, 1'b0, 24'h01234, 3'd3, 1'b1, 1'b1,
                       24'h05678, 3'd2, 1'b0, 1'b1);
        bus.tlbw_we = 1; bus.tlbw_index = IW'(3); bus.tlbw_wdata = e3;
        applyStimulus();
        bus.asid = 8'h05;
        bus.data_req = 1; bus.data_vaddr = 32'h0040_0ABC;
        applyStimulus();
        checkOutput("evenPaddr", bus.data_paddr, 32'h0123_4ABC);
        checkOutput("evenDirty", bus.data_dirty, 1'b1);
        bus.data_req = 1; bus.data_vaddr = 32'h0040_1ABC;
        applyStimulus();
        checkOutput("oddPaddr", bus.data_paddr, 32'h0567_8ABC);
        checkOutput("oddUncached", bus.data_uncached, 1'b1);

        // A different ASID misses; the same entry marked global hits.
        bus.asid = 8'h06;
        bus.data_req = 1; bus.data_vaddr = 32'h0040_0ABC;
        applyStimulus();
        checkOutput("asidMiss", bus.data_miss, 1'b1);
        e3.g = 1'b1;
        bus.tlbw_we = 1; bus.tlbw_index = IW'(3); bus.tlbw_wdata = e3;
        applyStimulus();
        bus.data_req = 1; bus.data_vaddr = 32'h0040_0ABC;
        applyStimulus();
        checkOutput("globalHit", bus.data_miss, 1'b0);

        // Entries 2 and 7 match the same address: the lowest index wins. Then read entry 7 back.
        bus.asid = 8'h05;
        e2 = makeEntry(19'h00300, 8'h05, 1'b0, 24'h0AAAA, 3'd3, 1'b0, 1'b1,
                       24'h0BBBB, 3'd3, 1'b1, 1'b1);
        e7 = makeEntry(19'h00300, 8'h05, 1'b0, 24'hFCCCC, 3'd2, 1'b1, 1'b0,
                       24'h3DDDD, 3'd1, 1'b0, 1'b1);
        bus.tlbw_we = 1; bus.tlbw_index = IW'(2); bus.tlbw_wdata = e2;
        applyStimulus();
        bus.tlbw_we = 1; bus.tlbw_index = IW'(7); bus.tlbw_wdata = e7;
        applyStimulus();
        bus.tlbp_req = 1; bus.tlbp_vpn2 = 19'h00300;
        bus.tlbr_req = 1; bus.tlbr_index = IW'(7);
        applyStimulus();
        checkOutput("probeLowest", bus.tlbp_res, 32'h0000_0002);
        checkOutput("readIdx7", bus.tlbr_res, e7);

        // A write and a lookup in the same cycle: the lookup sees the old entry.
        // The next lookup sees the new one.
        bus.tlbw_we = 1; bus.tlbw_index = IW'(3);
        bus.tlbw_wdata = makeEntry(19'h00200, 8'h05, 1'b0, 24'h01234, 3'd3, 1'b1, 1'b0,
                                   24'h05678, 3'd2, 1'b0, 1'b1);
        bus.inst_req = 1; bus.inst_vaddr = 32'h0040_0ABC;
        applyStimulus();
        checkOutput("preWriteInvalid", bus.inst_invalid, 1'b0);
        checkOutput("preWritePaddr", bus.inst_paddr, 32'h0123_4ABC);
        bus.inst_req = 1; bus.inst_vaddr = 32'h0040_0ABC;
        applyStimulus();
        checkOutput("postWriteInvalid", bus.inst_invalid, 1'b1);
        checkOutput("postWriteMiss", bus.inst_miss, 1'b0);

        // Both ports active in one cycle, each on a different page.
        bus.inst_req = 1; bus.inst_vaddr = 32'h0060_0456;
        bus.data_req = 1; bus.data_vaddr = 32'h0040_1123;
        applyStimulus();
        checkOutput("dualInst", bus.inst_paddr, 32'h0AAA_A456);
        checkOutput("dualData", bus.data_paddr, 32'h0567_8123);

        // Reset during active requests, then probe an address that hit before.
        rst = 1;
        bus.inst_req = 1; bus.data_req = 1; bus.tlbp_req = 1; bus.tlbw_we = 1;
        applyStimulus();
        checkOutput("rstInstPaddr", bus.inst_paddr, 32'h0);
        bus.tlbp_req = 1; bus.tlbp_vpn2 = 19'h00200;
        applyStimulus();
        checkOutput("rstProbeMiss", bus.tlbp_res, 32'h8000_0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.asid       = 8'($urandom_range(0, 3));
            bus.inst_req   = 1'($urandom_range(0, 1));
            bus.inst_vaddr = randVaddr();
            bus.data_req   = 1'($urandom_range(0, 1));
            bus.data_vaddr = randVaddr();
            bus.tlbp_req   = 1'($urandom_range(0, 1));
            bus.tlbp_vpn2  = randVpn2();
            bus.tlbr_req   = 1'($urandom_range(0, 1));
            bus.tlbr_index = IW'($urandom);
            bus.tlbw_we    = ($urandom_range(0, 2) == 0);
            bus.tlbw_index = IW'($urandom);
            bus.tlbw_wdata = makeEntry(randVpn2(), 8'($urandom_range(0, 3)),
                                       ($urandom_range(0, 3) == 0),
                                       24'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                                       24'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
